rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Produces a registered 3-bit grant index and a one-hot 8-bit grant; the one-hot output is the 3-to-8 decode of the index, gated by grant_valid.
- Sits in front of any shared datapath. Requesters hold the resource until they assert done, drop their request, or hit a hold timeout.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one grant may be held; legal range 1..2^CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i.
- done  input  1  owner releases the resource; sampled only in GRANT.
- grant_valid  output  1  a grant is active.
- grant_idx  output  3  index of the current owner; holds its last value when grant_valid=0.
- grant_onehot  output  8  (1 << grant_idx) when grant_valid=1, else 8'h00.
- busy_cnt  output  CNT_W  cycles elapsed in the current grant; 0 when idle.

Behaviour:
- Reset (async, immediate, including mid-grant): state=IDLE, ptr=0, grant_valid=0, grant_idx=0, grant_onehot=0, busy_cnt=0.
- States: IDLE and GRANT. ptr is a 3-bit priority pointer.
- IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - At the next edge: state=GRANT, grant_valid=1, grant_idx=selected index, busy_cnt=0.
  - Latency from req sampled high to grant_valid high is 1 cycle.
  - If req==0, remain in IDLE.
  - done is ignored in IDLE.
- GRANT: the release condition is any of:
  - done=1;
  - req[grant_idx]=0;
  - busy_cnt==HOLD_MAX-1.
- On release, at the next edge:
  - state=IDLE, grant_valid=0, busy_cnt=0;
  - ptr=grant_idx+1, wrapping 7->0;
  - grant_idx keeps its value.
- Otherwise in GRANT, busy_cnt increments by 1.
- Simultaneous release conditions cause a single release, with no extra effect.
- Exactly one IDLE (dead) cycle separates consecutive grants, even when requests are pending.
- Changes to other bits of req during GRANT do not affect the current owner.
- A grant lasts at most HOLD_MAX cycles of grant_valid=1.
  - With HOLD_MAX=1, every grant lasts exactly 1 cycle.
- done asserted in the first GRANT cycle releases after 1 cycle.
- grant_onehot is combinational from the registered grant_idx and grant_valid. It has exactly one bit set when valid and is zero otherwise.
- The pointer advances only on release, so starvation is impossible: every continuously-requesting requester is granted within 8 grants.

Test Plan:
- Reset: hold rst=1 with req=8'hFF. All outputs must read 0. Deassert rst. grant_valid=1 with grant_idx=0 and grant_onehot=8'h01 must appear exactly 1 cycle later.
- Rotation: req=8'b0000_0101 held, pulse done 1 cycle in each grant. Grant order must be 0, 2, 0, 2, with grant_valid low for exactly 1 cycle between grants; grant_onehot must be 8'h01, then 8'h04.
- Timeout: req=8'h10 held, done=0, HOLD_MAX=8. grant_idx=4 and grant_valid must stay high exactly 8 cycles (busy_cnt 0..7), then low 1 cycle, then re-grant to 4.
- Wrap-around: after a grant to idx 7 is released (ptr=0), apply req=8'h81. The next grant must be idx 0, and the one after it idx 7.
- Request drop: requester 3 granted, req[3] deasserted mid-grant with done=0. grant_valid must fall at the next edge and ptr must become 4. With req=8'h09, the next grant must be idx 0 (scan 4..7 finds nothing, wrap to 0).
- Reset mid-grant: assert rst asynchronously between edges while granted to idx 5. grant_valid and grant_onehot must drop to 0 immediately, without waiting for a clock edge. After release, the first grant must follow ptr=0 priority.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with done/drop/timeout release
module rr_arbiter8 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    input  logic             done,
    output logic             grant_valid,
    output logic [2:0]       grant_idx,
    output logic [7:0]       grant_onehot,
    output logic [CNT_W-1:0] busy_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] sel_idx;
    logic       any_req;
    logic       release_grant;

    assign any_req = |req;

    // Walk offsets from farthest to nearest so the closest set bit to ptr wins.
    always_comb begin
        sel_idx = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                sel_idx = ptr + 3'(i);
            end
        end
    end

    assign release_grant = done | ~req[grant_idx] | (busy_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 3'd0;
            grant_idx <= 3'd0;
            busy_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy_cnt <= '0;
                    if (any_req) begin
                        grant_idx <= sel_idx;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        ptr      <= grant_idx + 3'd1;
                        busy_cnt <= '0;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                default: begin
                    busy_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        grant_valid  = (state == GRANT);
        grant_onehot = grant_valid ? (8'd1 << grant_idx) : 8'd0;
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed and randomized checks of rr_arbiter8 against a reference model
module tb_rr_arbiter8;

    localparam int HOLD_MAX = 8;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst;
    logic [7:0]       req;
    logic             done;
    logic             grant_valid;
    logic [2:0]       grant_idx;
    logic [7:0]       grant_onehot;
    logic [CNT_W-1:0] busy_cnt;

    int checks;
    int errors;

    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_cnt;

    rr_arbiter8 #(
        .HOLD_MAX(HOLD_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_onehot(grant_onehot),
        .busy_cnt    (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // One clock of arbiter behaviour, phrased directly from the release/scan rules.
    task automatic model_update(input logic [7:0] r, input logic d);
        if (!m_valid) begin
            if (r != 8'd0) begin
                for (int k = 0; k < 8; k++) begin
                    if (r[(m_ptr + k) % 8]) begin
                        m_idx = (m_ptr + k) % 8;
                        break;
                    end
                end
                m_valid = 1'b1;
                m_cnt   = 0;
            end
        end else if (d || !r[m_idx] || m_cnt == HOLD_MAX - 1) begin
            m_valid = 1'b0;
            m_ptr   = (m_idx + 1) % 8;
            m_cnt   = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},  32'(grant_valid),  32'(m_valid));
        check({tag, ".idx"},    32'(grant_idx),    32'(m_idx));
        check({tag, ".onehot"}, 32'(grant_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
        check({tag, ".busy"},   32'(busy_cnt),     32'(m_cnt));
    endtask

    // Called at a falling edge; drives inputs, clocks, checks at the next falling edge.
    task automatic step(input string tag, input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_update(r, d);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic sync_reset_pulse();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Asserts reset between edges and checks that outputs clear before any clock edge.
    task automatic async_reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".valid_now"},  32'(grant_valid),  32'd0);
        check({tag, ".onehot_now"}, 32'(grant_onehot), 32'd0);
        check({tag, ".idx_now"},    32'(grant_idx),    32'd0);
        check({tag, ".busy_now"},   32'(busy_cnt),     32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic       d;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 8'hFF;
        done   = 1'b0;
        model_reset();

        // Reset state with all requests pending
        @(negedge clk);
        @(negedge clk);
        check("rst.valid",  32'(grant_valid),  32'd0);
        check("rst.idx",    32'(grant_idx),    32'd0);
        check("rst.onehot", 32'(grant_onehot), 32'd0);
        check("rst.busy",   32'(busy_cnt),     32'd0);
        rst = 1'b0;
        step("first", 8'hFF, 1'b0);
        check("first.onehot_c", 32'(grant_onehot), 32'h01);

        // Rotation between requesters 0 and 2
        sync_reset_pulse();
        for (int k = 0; k < 4; k++) begin
            step("rot.grant", 8'h05, 1'b0);
            check("rot.idx_c",    32'(grant_idx),    (k % 2 == 0) ? 32'd0 : 32'd2);
            check("rot.onehot_c", 32'(grant_onehot), (k % 2 == 0) ? 32'h01 : 32'h04);
            step("rot.rel", 8'h05, 1'b1);
            check("rot.dead_c", 32'(grant_valid), 32'd0);
        end

        // Hold timeout on a single requester
        sync_reset_pulse();
        for (int k = 0; k < HOLD_MAX; k++) begin
            step("tmo.hold", 8'h10, 1'b0);
            check("tmo.busy_c", 32'(busy_cnt), 32'(k));
        end
        step("tmo.rel", 8'h10, 1'b0);
        check("tmo.dead_c", 32'(grant_valid), 32'd0);
        step("tmo.regrant", 8'h10, 1'b0);
        check("tmo.idx_c", 32'(grant_idx), 32'd4);

        // Pointer wrap from 7 back to 0
        sync_reset_pulse();
        step("wrap.g7", 8'h80, 1'b0);
        step("wrap.r7", 8'h80, 1'b1);
        step("wrap.g0", 8'h81, 1'b0);
        check("wrap.idx0_c", 32'(grant_idx), 32'd0);
        step("wrap.r0", 8'h81, 1'b1);
        step("wrap.g7b", 8'h81, 1'b0);
        check("wrap.idx7_c", 32'(grant_idx), 32'd7);

        // Owner drops its request mid-grant
        sync_reset_pulse();
        step("drop.g3", 8'h08, 1'b0);
        step("drop.hold", 8'h08, 1'b0);
        step("drop.rel", 8'h00, 1'b0);
        check("drop.dead_c", 32'(grant_valid), 32'd0);
        step("drop.g0", 8'h09, 1'b0);
        check("drop.idx0_c", 32'(grant_idx), 32'd0);

        // Asynchronous reset while granted to 5
        sync_reset_pulse();
        step("armid.g5", 8'h20, 1'b0);
        step("armid.hold", 8'h20, 1'b0);
        async_reset_pulse("armid");
        step("armid.after", 8'h21, 1'b0);
        check("armid.idx0_c", 32'(grant_idx), 32'd0);

        // Randomized traffic against the model
        r = 8'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom) & 8'($urandom);
            end
            d = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                async_reset_pulse("rnd.rst");
            end else begin
                step("rnd", r, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
